saed32_64x8_req_ctrl: RTL

//  Dual-channel request front-end that drives both ports of the SAED32 64x8 dual-port SRAM wrapper.

---
 rtl/saed32_64x8_req_ctrl_if.sv | 26 ++
 rtl/saed32_64x8_req_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/saed32_64x8_req_ctrl_if.sv
// Per-channel client interface of the SAED32 64x8 request front-end:
// valid/ready request path plus valid/ready read-response path.
interface saed32_64x8_req_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/saed32_64x8_req_ctrl.sv
// Dual-channel request front-end for the SAED32 64x8 dual-port SRAM wrapper:
// collision arbitration with alternating priority and credit-limited response FIFOs.
module saed32_64x8_req_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    saed32_64x8_req_ctrl_if.slave ch0,
    saed32_64x8_req_ctrl_if.slave ch1,
    output logic                  CE0,
    output logic                  CE1,
    output logic                  WE0,
    output logic                  WE1,
    output logic [ADDR_W-1:0]     A0,
    output logic [ADDR_W-1:0]     A1,
    output logic [DATA_W-1:0]     D0,
    output logic [DATA_W-1:0]     D1,
    output logic [DATA_W-1:0]     WEM0,
    output logic [DATA_W-1:0]     WEM1,
    input  logic [DATA_W-1:0]     Q0,
    input  logic [DATA_W-1:0]     Q1
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]        req_v;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [DATA_W-1:0] req_wmask [2];
    logic [DATA_W-1:0] q_in      [2];
    logic [1:0]        rsp_r;

    logic [1:0]        req_rdy;
    logic [1:0]        ce;
    logic [1:0]        can_rd;
    logic [1:0]        loser;
    logic              collision;

    logic              prio_q, prio_d;
    logic [1:0]        inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];
    logic [DATA_W-1:0] fifo_q   [2][RSP_DEPTH];

    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        rsp_v;
    logic [DATA_W-1:0] rdata    [2];

    assign req_v[0]     = ch0.req_valid;
    assign req_v[1]     = ch1.req_valid;
    assign req_we[0]    = ch0.req_we;
    assign req_we[1]    = ch1.req_we;
    assign req_addr[0]  = ch0.req_addr;
    assign req_addr[1]  = ch1.req_addr;
    assign req_wdata[0] = ch0.req_wdata;
    assign req_wdata[1] = ch1.req_wdata;
    assign req_wmask[0] = ch0.req_wmask;
    assign req_wmask[1] = ch1.req_wmask;
    assign rsp_r[0]     = ch0.rsp_ready;
    assign rsp_r[1]     = ch1.rsp_ready;
    assign q_in[0]      = Q0;
    assign q_in[1]      = Q1;

    // Read/read to the same word is harmless on a dual-port macro; only writes collide.
    assign collision = (&req_v) & (req_addr[0] == req_addr[1]) & (|req_we);
    assign loser     = prio_q ? 2'b01 : 2'b10;
    assign prio_d    = prio_q ^ collision;

    // Credit counts both buffered entries and the read whose data is still on Q.
    always_comb begin
        can_rd  = '0;
        req_rdy = '0;
        ce      = '0;
        for (int c = 0; c < 2; c++) begin
            can_rd[c]  = (cnt_q[c] + CNT_W'(inflight_q[c])) < CNT_W'(RSP_DEPTH);
            req_rdy[c] = ~RST & ~(collision & loser[c]) & (req_we[c] | can_rd[c]);
            ce[c]      = req_v[c] & req_rdy[c];
        end
    end

    assign inflight_d = ce & ~req_we;

    assign CE0  = ce[0];
    assign CE1  = ce[1];
    assign WE0  = ce[0] & req_we[0];
    assign WE1  = ce[1] & req_we[1];
    assign A0   = ce[0] ? req_addr[0]  : '0;
    assign A1   = ce[1] ? req_addr[1]  : '0;
    assign D0   = ce[0] ? req_wdata[0] : '0;
    assign D1   = ce[1] ? req_wdata[1] : '0;
    assign WEM0 = (ce[0] & req_we[0]) ? req_wmask[0] : '0;
    assign WEM1 = (ce[1] & req_we[1]) ? req_wmask[1] : '0;

    assign ch0.req_ready = req_rdy[0];
    assign ch1.req_ready = req_rdy[1];

    assign push = inflight_q;

    always_comb begin
        rsp_v = '0;
        pop   = '0;
        for (int c = 0; c < 2; c++) begin
            rsp_v[c]    = (cnt_q[c] != '0);
            pop[c]      = rsp_v[c] & rsp_r[c];
            rdata[c]    = fifo_q[c][rd_ptr_q[c]];
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
            cnt_d[c]    = cnt_q[c];
            if (push[c] & ~pop[c]) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end else if (pop[c] & ~push[c]) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
        end
    end

    assign ch0.rsp_valid = rsp_v[0];
    assign ch1.rsp_valid = rsp_v[1];
    assign ch0.rsp_rdata = rdata[0];
    assign ch1.rsp_rdata = rdata[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q     <= 1'b0;
            inflight_q <= '0;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    // Entry storage needs no reset: validity is carried entirely by cnt_q.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                fifo_q[c][wr_ptr_q[c]] <= q_in[c];
            end
        end
    end
endmodule
